// File: rtl/axi_lite_master_if.sv
// AXI-Lite channel bundle shared by an initiator (master) and a target (slave).
// The five channels are kept together so they can be passed as one port.
interface axi_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: one request in, one AXI transaction out,
// one response back. A response timeout abandons the transaction and locks the block.
module axi_lite_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    axi_lite_if.master    m_axi,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          rsp_timeout_o,
    output logic          busy_o,
    output logic          bus_hung_o
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_e;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d, bus_hung_q, bus_hung_d;
    logic          inFlight, timeoutHit;

    assign inFlight   = (state_q == WR_AW_W) || (state_q == WR_B) ||
                        (state_q == RD_AR)   || (state_q == RD_R);
    // The counter is cleared on accept, so it holds TIMEOUT-1 in the last allowed cycle.
    assign timeoutHit = inFlight && (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        bus_hung_d    = bus_hung_q;

        if (inFlight) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_valid_i && !bus_hung_q) begin
                    cnt_d = '0;
                    if (req_write_i) begin
                        awaddr_d  = req_addr_i;
                        wdata_d   = req_wdata_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = req_addr_i;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (m_axi.bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = (m_axi.bresp == 2'b10) || (m_axi.bresp == 2'b11);
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                    state_d       = RSP;
                end
            end
            RD_AR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (m_axi.rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = (m_axi.rresp == 2'b10) || (m_axi.rresp == 2'b11);
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = rsp_err_d ? '0 : m_axi.rdata;
                    state_d       = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A real B/R response in the expiry cycle wins; anything short of that is abandoned.
        if (timeoutHit && (state_d != RSP)) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            bus_hung_d    = 1'b1;
            state_d       = RSP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            bus_hung_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            bus_hung_q    <= bus_hung_d;
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign req_ready_o   = (state_q == IDLE) && !bus_hung_q;
    assign busy_o        = (state_q != IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign bus_hung_o    = bus_hung_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the slave side of the bus is driven step by step
// and every cycle-accurate expectation below is written out by hand.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy, bus_hung;
    logic [31:0] rsp_rdata;
    logic [31:0] gpioOut = '0;
    int          bCount = 0;
    int          checks = 0;
    int          fails  = 0;
    int          lat;

    axi_lite_if #(.AW(32), .DW(32)) axi ();

    axi_lite_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .m_axi(axi),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .busy_o(busy), .bus_hung_o(bus_hung)
    );

    always #5 clk = ~clk;

    // Stand-in for the GPIO data-out register plus a count of accepted B beats.
    always @(posedge clk) begin
        if (axi.wvalid && axi.wready) gpioOut <= axi.wdata;
        if (axi.bvalid && axi.bready) bCount <= bCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        axi.awready = 1'b1; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        tick(); tick();
        checkOutput("rst_awvalid", axi.awvalid, 0);
        checkOutput("rst_wvalid", axi.wvalid, 0);
        checkOutput("rst_bready", axi.bready, 0);
        checkOutput("rst_arvalid", axi.arvalid, 0);
        checkOutput("rst_rready", axi.rready, 0);
        checkOutput("rst_awaddr", axi.awaddr, 0);
        checkOutput("rst_araddr", axi.araddr, 0);
        checkOutput("rst_wdata", axi.wdata, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_rsp_timeout", rsp_timeout, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bus_hung", bus_hung, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_req_ready", req_ready, 1);

        $display("[TB] GPIO write 0xA5 to 0x04");
        applyStimulus(1'b1, 32'h4, 32'hA5);
        tick(); req_valid = 1'b0;
        checkOutput("w1_awvalid", axi.awvalid, 1);
        checkOutput("w1_wvalid", axi.wvalid, 1);
        checkOutput("w1_awaddr", axi.awaddr, 32'h4);
        checkOutput("w1_wdata", axi.wdata, 32'hA5);
        checkOutput("w1_req_ready", req_ready, 0);
        tick();
        checkOutput("w1_awvalid_drop", axi.awvalid, 0);
        checkOutput("w1_wvalid_hold", axi.wvalid, 1);
        axi.wready = 1'b1;
        tick();
        checkOutput("w1_wvalid_drop", axi.wvalid, 0);
        checkOutput("w1_bready", axi.bready, 1);
        axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00;
        tick();
        checkOutput("w1_bready_drop", axi.bready, 0);
        checkOutput("w1_rsp_valid", rsp_valid, 1);
        checkOutput("w1_rsp_err", rsp_err, 0);
        checkOutput("w1_rsp_rdata", rsp_rdata, 0);
        axi.bvalid = 1'b0;
        tick();
        checkOutput("w1_rsp_done", rsp_valid, 0);
        checkOutput("w1_idle_ready", req_ready, 1);
        checkOutput("w1_gpio", gpioOut, 32'hA5);

        $display("[TB] read 0x08 with two ARREADY wait cycles");
        axi.arready = 1'b0;
        applyStimulus(1'b0, 32'h8, 32'h0);
        tick(); req_valid = 1'b0;
        checkOutput("r2_arvalid_t1", axi.arvalid, 1);
        checkOutput("r2_araddr", axi.araddr, 32'h8);
        tick();
        checkOutput("r2_arvalid_t2", axi.arvalid, 1);
        tick();
        checkOutput("r2_arvalid_t3", axi.arvalid, 1);
        axi.arready = 1'b1;
        tick();
        checkOutput("r2_arvalid_drop", axi.arvalid, 0);
        checkOutput("r2_rready", axi.rready, 1);
        checkOutput("r2_rsp_not_yet", rsp_valid, 0);
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678; axi.rresp = 2'b00;
        tick();
        checkOutput("r2_rsp_valid_t5", rsp_valid, 1);
        checkOutput("r2_rdata", rsp_rdata, 32'h1234_5678);
        checkOutput("r2_rsp_err", rsp_err, 0);
        checkOutput("r2_rready_drop", axi.rready, 0);
        axi.rvalid = 1'b0;
        tick();

        $display("[TB] skewed write, WREADY three cycles before AWREADY");
        axi.awready = 1'b0; axi.wready = 1'b0;
        applyStimulus(1'b1, 32'h20, 32'h5A5A);
        tick(); req_valid = 1'b0;
        checkOutput("w3_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        axi.wready = 1'b1;
        tick();
        checkOutput("w3_wvalid_drop", axi.wvalid, 0);
        checkOutput("w3_awvalid_t2", axi.awvalid, 1);
        axi.wready = 1'b0;
        tick();
        checkOutput("w3_awvalid_t3", axi.awvalid, 1);
        tick();
        checkOutput("w3_awvalid_t4", axi.awvalid, 1);
        checkOutput("w3_no_bready", axi.bready, 0);
        axi.awready = 1'b1;
        tick();
        checkOutput("w3_awvalid_drop", axi.awvalid, 0);
        checkOutput("w3_bready", axi.bready, 1);
        axi.awready = 1'b0; axi.bvalid = 1'b1;
        tick();
        checkOutput("w3_rsp_valid", rsp_valid, 1);
        checkOutput("w3_rsp_err", rsp_err, 0);
        tick();
        checkOutput("w3_b_count", bCount, 2);
        checkOutput("w3_gpio", gpioOut, 32'h5A5A);
        axi.bvalid = 1'b0;

        $display("[TB] read with SLVERR, then EXOKAY read");
        axi.arready = 1'b1;
        applyStimulus(1'b0, 32'h30, 32'h0);
        tick(); req_valid = 1'b0;
        checkOutput("r4_arvalid", axi.arvalid, 1);
        tick();
        axi.rvalid = 1'b1; axi.rresp = 2'b10; axi.rdata = 32'hDEAD_BEEF;
        tick();
        checkOutput("r4_rsp_valid", rsp_valid, 1);
        checkOutput("r4_rsp_err", rsp_err, 1);
        checkOutput("r4_rsp_timeout", rsp_timeout, 0);
        checkOutput("r4_rsp_rdata", rsp_rdata, 0);
        axi.rvalid = 1'b0; axi.rresp = 2'b00;
        tick();
        checkOutput("r4_next_ready", req_ready, 1);
        applyStimulus(1'b0, 32'h0C, 32'h0);
        tick(); req_valid = 1'b0;
        checkOutput("r4b_araddr", axi.araddr, 32'h0C);
        tick();
        axi.rvalid = 1'b1; axi.rresp = 2'b01; axi.rdata = 32'hCAFE_F00D;
        tick();
        checkOutput("r4b_rsp_err", rsp_err, 0);
        checkOutput("r4b_rdata", rsp_rdata, 32'hCAFE_F00D);
        axi.rvalid = 1'b0; axi.rresp = 2'b00;
        tick();

        $display("[TB] response held for five cycles");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h40, 32'h0);
        tick(); req_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1; axi.rdata = 32'h55AA_33CC;
        tick();
        axi.rvalid = 1'b0; axi.rdata = '0;
        applyStimulus(1'b1, 32'h10, 32'h77);
        for (int i = 0; i < 5; i++) begin
            checkOutput("h5_rsp_valid", rsp_valid, 1);
            checkOutput("h5_rsp_rdata", rsp_rdata, 32'h55AA_33CC);
            checkOutput("h5_req_ready", req_ready, 0);
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("h5_rsp_done", rsp_valid, 0);
        checkOutput("h5_req_ready_after", req_ready, 1);
        tick(); req_valid = 1'b0;
        checkOutput("h5_next_awvalid", axi.awvalid, 1);
        checkOutput("h5_next_awaddr", axi.awaddr, 32'h10);
        axi.awready = 1'b1; axi.wready = 1'b1;
        tick();
        axi.bvalid = 1'b1;
        tick();
        checkOutput("h5_next_rsp", rsp_valid, 1);
        axi.bvalid = 1'b0;
        tick();

        $display("[TB] write with no B response, TIMEOUT=16");
        rsp_ready = 1'b0;
        lat = 0;
        applyStimulus(1'b1, 32'h50, 32'h1);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        checkOutput("to_latency", lat, 17);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_timeout", rsp_timeout, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_bus_hung", bus_hung, 1);
        checkOutput("to_bready_drop", axi.bready, 0);
        checkOutput("to_req_ready", req_ready, 0);
        tick();
        checkOutput("to_rsp_hold", rsp_valid, 1);
        #3 rst = 1'b1;
        #1;
        checkOutput("to_rst_rsp_valid", rsp_valid, 0);
        checkOutput("to_rst_rsp_err", rsp_err, 0);
        checkOutput("to_rst_rsp_timeout", rsp_timeout, 0);
        checkOutput("to_rst_bus_hung", bus_hung, 0);
        checkOutput("to_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("to_recovered_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
